// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for an RV32I single-issue core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB over a shared
// datapath, handshakes with instruction/data memory, traps on unknown opcodes
// and counts retired instructions.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   opcode/funct3         IR fields (stable from the cycle after ir_write)
//   i_type_imm            IR[31:20]
//   branch_taken          ALU compare result, sampled in EXEC
//   imem_ready/dmem_ready memory handshake completions
//   imem_req, dmem_req, dmem_we                  memory requests
//   ir_write, pc_write, pc_src, reg_write, wb_sel, imm_sel, alu_src_a_pc
//                                                datapath strobes
//   illegal_insn          high while trapped
//   instret               retired-instruction counter
module multicycle_sequencer #(
    parameter int unsigned INSTRET_WIDTH = 32,
    parameter bit          TRAP_STICKY   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [11:0]              i_type_imm,
    input  logic                     branch_taken,
    input  logic                     imem_ready,
    input  logic                     dmem_ready,
    output logic                     imem_req,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic [1:0]               pc_src,
    output logic                     reg_write,
    output logic [1:0]               wb_sel,
    output logic [2:0]               imm_sel,
    output logic                     alu_src_a_pc,
    output logic                     illegal_insn,
    output logic [INSTRET_WIDTH-1:0] instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t                   r_state;
    logic [INSTRET_WIDTH-1:0] r_instret;

    logic       w_is_r, w_is_i_alu, w_is_load, w_is_store, w_is_branch;
    logic       w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal;
    logic [2:0] w_cls_imm;
    logic       w_retire;
    logic       w_unused;

    // Instruction class decode
    assign w_is_r      = (opcode == OP_R);
    assign w_is_i_alu  = (opcode == OP_I_ALU);
    assign w_is_load   = (opcode == OP_LOAD);
    assign w_is_store  = (opcode == OP_STORE);
    assign w_is_branch = (opcode == OP_BRANCH);
    assign w_is_jal    = (opcode == OP_JAL);
    assign w_is_jalr   = (opcode == OP_JALR);
    assign w_is_lui    = (opcode == OP_LUI);
    assign w_is_auipc  = (opcode == OP_AUIPC);
    assign w_legal     = w_is_r | w_is_i_alu | w_is_load | w_is_store | w_is_branch
                       | w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;

    // SRLI and SRAI share the zero-extended shamt select, so the
    // arithmetic-shift bit and the rest of the immediate never steer control.
    assign w_unused = ^i_type_imm;

    // Immediate select held for the whole instruction so operands stay stable
    always_comb begin
        w_cls_imm = 3'd0;
        if (w_is_i_alu)
            w_cls_imm = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? 3'd2 : 3'd1;
        else if (w_is_load || w_is_jalr)
            w_cls_imm = 3'd1;
        else if (w_is_store)
            w_cls_imm = 3'd3;
        else if (w_is_branch)
            w_cls_imm = 3'd4;
        else if (w_is_lui || w_is_auipc)
            w_cls_imm = 3'd5;
        else if (w_is_jal)
            w_cls_imm = 3'd6;
    end

    // Retire points: branch in EXEC, store on data completion, every WB
    assign w_retire = ((r_state == S_EXEC) && w_is_branch)
                    || ((r_state == S_MEM) && dmem_ready && w_is_store)
                    || (r_state == S_WB);

    // State sequencing and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_instret <= '0;
        end else begin
            r_instret <= r_instret + INSTRET_WIDTH'(w_retire);
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  if (imem_ready) r_state <= S_DECODE;
                S_DECODE: r_state <= w_legal ? S_EXEC : S_TRAP;
                S_EXEC: begin
                    if (w_is_load || w_is_store) r_state <= S_MEM;
                    else if (w_is_branch)        r_state <= S_FETCH;
                    else                         r_state <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) r_state <= w_is_store ? S_FETCH : S_WB;
                end
                S_WB:     r_state <= S_FETCH;
                S_TRAP:   if (!TRAP_STICKY) r_state <= S_FETCH;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath strobes decoded from state and the current instruction
    always_comb begin
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        imm_sel      = 3'd0;
        alu_src_a_pc = 1'b0;
        illegal_insn = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            S_EXEC: begin
                imm_sel      = w_cls_imm;
                alu_src_a_pc = w_is_auipc;
                if (w_is_branch) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken ? 2'd1 : 2'd0;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                imm_sel  = w_cls_imm;
                if (dmem_ready && w_is_store) pc_write = 1'b1;
            end
            S_WB: begin
                reg_write    = 1'b1;
                pc_write     = 1'b1;
                imm_sel      = w_cls_imm;
                alu_src_a_pc = w_is_auipc;
                if (w_is_load)                  wb_sel = 2'd1;
                else if (w_is_jal || w_is_jalr) wb_sel = 2'd2;
                else if (w_is_lui)              wb_sel = 2'd3;
                if (w_is_jal)       pc_src = 2'd2;
                else if (w_is_jalr) pc_src = 2'd3;
            end
            S_TRAP:  illegal_insn = 1'b1;
            default: ;
        endcase
    end

    assign instret = r_instret;

endmodule
